// File: rtl/cpu_snoop_fifo.sv
`default_nettype none
// ============================================================================
// cpu_snoop_fifo : snoops 68000 framebuffer writes into a pixClk-domain FIFO
//                  and tracks the VIA buffer-select bit.   Rev 1.0
// ============================================================================
module cpu_snoop_fifo #(
  parameter int          DEPTH  = 8,
  parameter logic [13:0] OFS_LO = 14'h1380,
  parameter logic [13:0] OFS_HI = 14'h3E3F
) (
  input  logic                     i_pixClk,
  input  logic                     i_reset,
  input  logic [22:0]              i_cpuAddr,
  input  logic [15:0]              i_cpuData,
  input  logic                     i_ncpuAS,
  input  logic                     i_ncpuUDS,
  input  logic                     i_ncpuLDS,
  input  logic                     i_cpuRnW,
  input  logic [2:0]               i_ramSize,
  output logic                     o_wrValid,
  input  logic                     i_wrReady,
  output logic [14:0]              o_wrAddr,
  output logic [15:0]              o_wrData,
  output logic                     o_wrUDS,
  output logic                     o_wrLDS,
  output logic [$clog2(DEPTH):0]   o_fifoCount,
  output logic                     o_overflow,
  output logic                     o_bufSelect
);

  localparam int                c_AW   = $clog2(DEPTH);
  localparam int                c_CW   = c_AW + 1;
  localparam int                c_EW   = 33;
  localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_QUAL     = 2'd1,
    S_CAPTURE  = 2'd2,
    S_WAIT_END = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic r_as_meta, r_as_sync, r_as_prev;
  logic r_uds_meta, r_uds_sync;
  logic r_lds_meta, r_lds_sync;
  logic r_rnw_meta, r_rnw_sync;

  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_EW-1:0] r_head;
  logic            r_overflow;
  logic            r_bufSelect;

  logic            w_as_fall;
  logic            w_capture;
  logic            w_fb_hit;
  logic            w_via_hit;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [13:0]     w_offset;
  logic [c_EW-1:0] w_entry;
  logic [c_AW-1:0] w_rd_next;
  logic [c_CW-1:0] w_count_next;
  logic [c_EW-1:0] w_head_next;

  // AS syncs reset low so a bus cycle already running at reset release shows no falling edge.
  always_ff @(posedge i_pixClk) begin
    if (i_reset) begin
      r_as_meta  <= 1'b0;
      r_as_sync  <= 1'b0;
      r_as_prev  <= 1'b0;
      r_uds_meta <= 1'b1;
      r_uds_sync <= 1'b1;
      r_lds_meta <= 1'b1;
      r_lds_sync <= 1'b1;
      r_rnw_meta <= 1'b1;
      r_rnw_sync <= 1'b1;
    end else begin
      r_as_meta  <= i_ncpuAS;
      r_as_sync  <= r_as_meta;
      r_as_prev  <= r_as_sync;
      r_uds_meta <= i_ncpuUDS;
      r_uds_sync <= r_uds_meta;
      r_lds_meta <= i_ncpuLDS;
      r_lds_sync <= r_lds_meta;
      r_rnw_meta <= i_cpuRnW;
      r_rnw_sync <= r_rnw_meta;
    end
  end

  assign w_as_fall = r_as_prev & ~r_as_sync;

  always_ff @(posedge i_pixClk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_as_fall) w_state_next = S_QUAL;
      S_QUAL: begin
        if (r_as_sync)                      w_state_next = S_IDLE;
        else if (r_rnw_sync)                w_state_next = S_WAIT_END;
        else if (!r_uds_sync || !r_lds_sync) w_state_next = S_CAPTURE;
      end
      S_CAPTURE:  w_state_next = S_WAIT_END;
      S_WAIT_END: if (r_as_sync) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Address/data are stable by the time synced DS is seen low, so they are sampled raw.
  assign w_capture = (r_state == S_CAPTURE);
  assign w_fb_hit  = (i_cpuAddr[22:21] == 2'b00) && (i_cpuAddr[20:18] == i_ramSize) &&
                     (i_cpuAddr[17:15] == 3'b111) &&
                     (i_cpuAddr[13:0] >= OFS_LO) && (i_cpuAddr[13:0] <= OFS_HI);
  assign w_via_hit = (i_cpuAddr[22:18] == 5'h1D) && (i_cpuAddr[11:7] == 5'h1F) && !r_uds_sync;
  assign w_offset  = i_cpuAddr[13:0] - OFS_LO;
  assign w_entry   = {~i_cpuAddr[14], w_offset, i_cpuData, ~r_uds_sync, ~r_lds_sync};

  assign w_full    = (r_count == c_FULL);
  assign w_pop     = (r_count != '0) && i_wrReady;
  assign w_push    = w_capture && w_fb_hit && (!w_full || w_pop);
  assign w_drop    = w_capture && w_fb_hit && w_full && !w_pop;
  assign w_rd_next = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CW'(1);
      2'b01:   w_count_next = r_count - c_CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Head register: the next head may be the entry being written this very cycle.
  assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? w_entry : r_mem[w_rd_next];

  always_ff @(posedge i_pixClk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge i_pixClk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_head      <= '0;
      r_overflow  <= 1'b0;
      r_bufSelect <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_push)              r_wr_ptr    <= r_wr_ptr + c_AW'(1);
      if (w_count_next != '0)  r_head      <= w_head_next;
      if (w_drop)              r_overflow  <= 1'b1;
      if (w_capture && w_via_hit) r_bufSelect <= ~i_cpuData[14];
    end
  end

  assign o_wrValid   = (r_count != '0);
  assign o_wrAddr    = r_head[32:18];
  assign o_wrData    = r_head[17:2];
  assign o_wrUDS     = r_head[1];
  assign o_wrLDS     = r_head[0];
  assign o_fifoCount = r_count;
  assign o_overflow  = r_overflow;
  assign o_bufSelect = r_bufSelect;

endmodule
`default_nettype wire
